// File: rtl/spi_flash_pkg.sv
// Shared state codes, command ops and flash opcodes for the SPI flash command sequencer.
package spi_flash_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StCmd   = 3'd1;
  localparam state_t StAddr2 = 3'd2;
  localparam state_t StAddr1 = 3'd3;
  localparam state_t StAddr0 = 3'd4;
  localparam state_t StDummy = 3'd5;
  localparam state_t StData  = 3'd6;
  localparam state_t StGap   = 3'd7;

  typedef enum logic [1:0] {
    OpReadId     = 2'b00,
    OpRead       = 2'b01,
    OpReadStatus = 2'b10,
    OpRsvd       = 2'b11
  } op_e;

  localparam logic [7:0] OpcReadId     = 8'h9F;
  localparam logic [7:0] OpcReadStatus = 8'h05;
  localparam logic [7:0] OpcRead       = 8'h03;
  localparam logic [7:0] OpcFastRead   = 8'h0B;

  localparam int unsigned IdBytes = 3;

  // read_opc lets the caller pick plain or fast read without the package knowing the build.
  function automatic logic [7:0] opcode_for(op_e op, logic [7:0] read_opc);
    case (op)
      OpReadId:     return OpcReadId;
      OpReadStatus: return OpcReadStatus;
      default:      return read_opc;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_wdog.sv
// Byte-done watchdog: counts sclk cycles while enabled, restarts on clear, flags expiry.
module spi_flash_wdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != Last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th enabled cycle since the last clear; a same-cycle flag wins.
  assign expired = enable && !clear && (cnt_q == Last);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_seq.sv
// Command sequencer in front of the SPI flash byte engine (READ_ID / READ / READ_STATUS).
// Build option: define SPI_FLASH_FAST_READ_EN for opcode 0x0B with one dummy byte.
module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             busy,
  output logic             err,
  output logic             spi_en,
  output logic [7:0]       spi_datasend,
  input  logic             spi_dataflag,
  input  logic [7:0]       spi_datarecv
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] ReadOpcode = OpcFastRead;
`else
  localparam logic [7:0] ReadOpcode = OpcRead;
`endif

  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t           state_q, state_d;
  op_e              op_q, op_d, cmd_op_e;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             spi_en_q, spi_en_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             err_q, err_d;
  logic             wdog_expired;

  spi_flash_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .clear   (spi_dataflag),
    .enable  (spi_en_q),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    spi_en_d   = spi_en_q;
    tx_d       = tx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;
    cmd_op_e   = op_e'(cmd_op);

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_op_e == OpRsvd || (cmd_op_e == OpRead && cmd_len == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d  = StCmd;
            op_d     = cmd_op_e;
            addr_d   = cmd_addr;
            spi_en_d = 1'b1;
            tx_d     = opcode_for(cmd_op_e, ReadOpcode);
            case (cmd_op_e)
              OpRead:   cnt_d = cmd_len;
              OpReadId: cnt_d = LEN_W'(IdBytes);
              default:  cnt_d = LEN_W'(1);
            endcase
          end
        end
      end
      StCmd: begin
        if (spi_dataflag) begin
          if (op_q == OpRead) begin
            state_d = StAddr2;
            tx_d    = addr_q[23:16];
          end else begin
            state_d = StData;
            tx_d    = 8'h00;
          end
        end
      end
      StAddr2: begin
        if (spi_dataflag) begin
          state_d = StAddr1;
          tx_d    = addr_q[15:8];
        end
      end
      StAddr1: begin
        if (spi_dataflag) begin
          state_d = StAddr0;
          tx_d    = addr_q[7:0];
        end
      end
      StAddr0: begin
        if (spi_dataflag) begin
`ifdef SPI_FLASH_FAST_READ_EN
          state_d = StDummy;
`else
          state_d = StData;
`endif
          tx_d    = 8'h00;
        end
      end
      StDummy: begin
        if (spi_dataflag) begin
          state_d = StData;
          tx_d    = 8'h00;
        end
      end
      StData: begin
        if (spi_dataflag) begin
          rd_data_d  = spi_datarecv;
          rd_valid_d = 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            rd_last_d = 1'b1;
            spi_en_d  = 1'b0;
            state_d   = StGap;
            gap_d     = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(CS_GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stalled engine: drop CS and let the gap run out without a final-byte marker.
    if (wdog_expired) begin
      state_d    = StGap;
      gap_d      = '0;
      spi_en_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpReadId;
      addr_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      spi_en_q   <= 1'b0;
      tx_q       <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      spi_en_q   <= spi_en_d;
      tx_q       <= tx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign spi_en       = spi_en_q;
  assign spi_datasend = tx_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a simple flag-driven byte engine model.
module tb_spi_flash_seq;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned TIMEOUT = 4096;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] ExpReadOpc = 8'h0B;
  localparam int         ReadHdr    = 5;
`else
  localparam logic [7:0] ExpReadOpc = 8'h03;
  localparam int         ReadHdr    = 4;
`endif

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [23:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic             busy;
  logic             err;
  logic             spi_en;
  logic [7:0]       spi_datasend;
  logic             spi_dataflag = 1'b0;
  logic [7:0]       spi_datarecv = 8'h00;

  spi_flash_seq #(
    .LEN_W   (LEN_W),
    .CS_GAP  (CS_GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .busy         (busy),
    .err          (err),
    .spi_en       (spi_en),
    .spi_datasend (spi_datasend),
    .spi_dataflag (spi_dataflag),
    .spi_datarecv (spi_datarecv)
  );

  always #5 sclk = ~sclk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] resp[$];
  logic [7:0] sent[$];
  logic [7:0] rdv[$];
  logic       rdl[$];
  int         err_cnt, last_cnt, en_seen;

  always @(negedge sclk) begin
    if (rd_valid) begin
      rdv.push_back(rd_data);
      rdl.push_back(rd_last);
    end
    if (rd_last) last_cnt++;
    if (err) err_cnt++;
    if (spi_en) en_seen++;
  end

  task automatic clear_log();
    sent.delete();
    rdv.delete();
    rdl.delete();
    err_cnt  = 0;
    last_cnt = 0;
    en_seen  = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] addr,
                       input logic [LEN_W-1:0] len);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge sclk);
    cmd_valid = 1'b0;
  endtask

  // Engine model: one flag every third cycle, recording the byte being shifted out.
  task automatic xfer(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge sclk);
      spi_datarecv = (i < resp.size()) ? resp[i] : 8'hA5;
      spi_dataflag = 1'b1;
      sent.push_back(spi_datasend);
      @(negedge sclk);
      spi_dataflag = 1'b0;
      spi_datarecv = 8'h00;
    end
    #1;
  endtask

  task automatic wait_idle(output int gap, output bit to);
    gap = 0;
    to  = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (cmd_ready) begin
        to = 1'b0;
        break;
      end
      if (busy && !spi_en) gap++;
      @(negedge sclk);
      #1;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({cmd_ready, busy, err, rd_valid, rd_last, spi_en} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, expected 100000",
               {cmd_ready, busy, err, rd_valid, rd_last, spi_en});
    end
    vectors++;
    if ({spi_datasend, rd_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 0000", {spi_datasend, rd_data});
    end
  endtask

  task automatic test_read_id(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] got;
    int gap;
    bit to;
    exp_tx = {8'h9F, 8'h00, 8'h00, 8'h00};
    exp_rx = {b0, b1, b2};
    clear_log();
    resp = {8'hFF, b0, b1, b2};
    issue(2'b00, 24'h0, '0);
    vectors++;
    if ({spi_en, cmd_ready, busy, spi_datasend} !== {3'b101, 8'h9F}) begin
      miscompares++;
      $display("FAIL id_start: got %h, expected %h", {spi_en, cmd_ready, busy, spi_datasend},
               {3'b101, 8'h9F});
    end
    xfer(4);
    for (int i = 0; i < 4; i++) begin
      got = (i < sent.size()) ? sent[i] : 8'hxx;
      vectors++;
      if (got !== exp_tx[i]) begin
        miscompares++;
        $display("FAIL id_tx[%0d]: got %h, expected %h", i, got, exp_tx[i]);
      end
    end
    vectors++;
    if (rdv.size() != 3) begin
      miscompares++;
      $display("FAIL id_rx_count: got %0d, expected 3", rdv.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rdv.size()) ? rdv[i] : 8'hxx;
      vectors++;
      if (got !== exp_rx[i] || (i < rdl.size() && rdl[i] !== (i == 2))) begin
        miscompares++;
        $display("FAIL id_rx[%0d]: got %h, expected %h (last on byte 2)", i, got, exp_rx[i]);
      end
    end
    vectors++;
    if (spi_en !== 1'b0 || last_cnt != 1) begin
      miscompares++;
      $display("FAIL id_end: got en=%b lasts=%0d, expected en=0 lasts=1", spi_en, last_cnt);
    end
    wait_idle(gap, to);
    vectors++;
    if (to || gap != CS_GAP) begin
      miscompares++;
      $display("FAIL id_gap: got %0d (timeout=%0d), expected %0d", gap, to, CS_GAP);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] got;
    int gap;
    bit to;
    exp_tx = {ExpReadOpc, 8'h01, 8'h23, 8'h45};
    if (ReadHdr == 5) exp_tx.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h00);
    exp_rx = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_log();
    resp.delete();
    for (int i = 0; i < ReadHdr; i++) resp.push_back(8'h5A);
    for (int i = 0; i < 4; i++) resp.push_back(exp_rx[i]);
    issue(2'b01, 24'h012345, LEN_W'(4));
    xfer(exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      got = (i < sent.size()) ? sent[i] : 8'hxx;
      vectors++;
      if (got !== exp_tx[i]) begin
        miscompares++;
        $display("FAIL rd_tx[%0d]: got %h, expected %h", i, got, exp_tx[i]);
      end
    end
    vectors++;
    if (rdv.size() != 4) begin
      miscompares++;
      $display("FAIL rd_rx_count: got %0d, expected 4", rdv.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < rdv.size()) ? rdv[i] : 8'hxx;
      vectors++;
      if (got !== exp_rx[i] || (i < rdl.size() && rdl[i] !== (i == 3))) begin
        miscompares++;
        $display("FAIL rd_rx[%0d]: got %h, expected %h (last on byte 3)", i, got, exp_rx[i]);
      end
    end
    wait_idle(gap, to);
    vectors++;
    if (to || gap < CS_GAP) begin
      miscompares++;
      $display("FAIL rd_gap: got %0d (timeout=%0d), expected >= %0d", gap, to, CS_GAP);
    end
  endtask

  task automatic test_read_status();
    int gap;
    bit to;
    clear_log();
    resp = {8'hFF, 8'h01};
    issue(2'b10, 24'h0, '0);
    // A second request while busy must be dropped, not queued.
    cmd_op    = 2'b01;
    cmd_len   = LEN_W'(5);
    cmd_valid = 1'b1;
    @(negedge sclk);
    cmd_valid = 1'b0;
    xfer(2);
    vectors++;
    if (sent.size() != 2 || sent[0] !== 8'h05 || sent[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL st_tx: got %0d bytes first %h, expected 2 bytes 05 00", sent.size(),
               (sent.size() > 0) ? sent[0] : 8'hxx);
    end
    vectors++;
    if (rdv.size() != 1 || rdv[0] !== 8'h01 || rdl[0] !== 1'b1 || spi_en !== 1'b0) begin
      miscompares++;
      $display("FAIL st_rx: got %0d strobes en=%b, expected 1 strobe data 01 last en=0",
               rdv.size(), spi_en);
    end
    // Flag during the gap must be ignored.
    @(negedge sclk);
    spi_dataflag = 1'b1;
    spi_datarecv = 8'h77;
    @(negedge sclk);
    spi_dataflag = 1'b0;
    #1;
    wait_idle(gap, to);
    repeat (3) @(negedge sclk);
    #1;
    vectors++;
    if (to || rdv.size() != 1 || busy !== 1'b0 || spi_en !== 1'b0) begin
      miscompares++;
      $display("FAIL st_after: got strobes=%0d busy=%b en=%b, expected 1 0 0", rdv.size(),
               busy, spi_en);
    end
  endtask

  task automatic test_reject();
    clear_log();
    issue(2'b11, 24'h0, LEN_W'(3));
    vectors++;
    if ({err, cmd_ready, busy, spi_en} !== 4'b1100) begin
      miscompares++;
      $display("FAIL rej_op: got %b, expected 1100", {err, cmd_ready, busy, spi_en});
    end
    @(negedge sclk);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL rej_pulse: got err=%b, expected 0", err);
    end
    issue(2'b01, 24'h000010, '0);
    vectors++;
    if ({err, cmd_ready, busy, spi_en} !== 4'b1100) begin
      miscompares++;
      $display("FAIL rej_len0: got %b, expected 1100", {err, cmd_ready, busy, spi_en});
    end
    repeat (4) @(negedge sclk);
    #1;
    vectors++;
    if (en_seen != 0 || err_cnt != 2) begin
      miscompares++;
      $display("FAIL rej_traffic: got en_cycles=%0d errs=%0d, expected 0 2", en_seen, err_cnt);
    end
  endtask

  task automatic test_timeout();
    int hi;
    int gap;
    bit to;
    clear_log();
    resp = {8'hFF};
    issue(2'b00, 24'h0, '0);
    xfer(1);
    hi = 0;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      if (!spi_en) break;
      hi++;
      @(negedge sclk);
      #1;
    end
    vectors++;
    if (hi != TIMEOUT) begin
      miscompares++;
      $display("FAIL to_cycles: got %0d, expected %0d", hi, TIMEOUT);
    end
    vectors++;
    if (err !== 1'b1 || spi_en !== 1'b0 || last_cnt != 0 || rdv.size() != 0) begin
      miscompares++;
      $display("FAIL to_abort: got err=%b en=%b lasts=%0d strobes=%0d, expected 1 0 0 0", err,
               spi_en, last_cnt, rdv.size());
    end
    wait_idle(gap, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL to_idle: got busy after bound, expected cmd_ready");
    end
    test_read_id(8'hC2, 8'h20, 8'h16);
  endtask

  task automatic test_reset_mid();
    clear_log();
    resp.delete();
    issue(2'b01, 24'h012345, LEN_W'(2));
    xfer(2);
    vectors++;
    if (spi_datasend !== 8'h23 || spi_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: got %h en=%b, expected 23 en=1", spi_datasend, spi_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({spi_en, cmd_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_async: got %b, expected 010", {spi_en, cmd_ready, busy});
    end
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    #1;
    vectors++;
    if ({spi_en, cmd_ready, busy, rd_valid, err} !== 5'b01000) begin
      miscompares++;
      $display("FAIL rst_release: got %b, expected 01000", {spi_en, cmd_ready, busy, rd_valid, err});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    test_reset();
    rst_n = 1'b1;
    @(negedge sclk);
    #1;
    test_read_id(8'hEF, 8'h40, 8'h18);
    test_read();
    test_read_status();
    test_reject();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
